// File: rtl/vx_execute_arbiter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vx_execute_arbiter_if
//   Bundles the request side (NUM_INPUTS issue slices) and the response side
//   (one functional-unit execute port) of the execute arbiter.
//
//   Request side, one bit or one DATAW slice per issue slice:
//     in_valid  [NUM_INPUTS]        per-slice request valid
//     in_data   [NUM_INPUTS*DATAW]  per-slice payload, slice i at [i*DATAW +: DATAW]
//     in_sop    [NUM_INPUTS]        first beat of the packet
//     in_eop    [NUM_INPUTS]        last beat of the packet
//     in_ready  [NUM_INPUTS]        per-slice accept (driven by the arbiter)
//   FU side:
//     out_valid / out_data / out_sop / out_eop / out_sel  (driven by the arbiter)
//     out_ready                                           (driven by the FU)
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (dispatch slices + FU)
// -----------------------------------------------------------------------------
interface vx_execute_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 512
);
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS-1:0]       in_valid;
    logic [NUM_INPUTS*DATAW-1:0] in_data;
    logic [NUM_INPUTS-1:0]       in_sop;
    logic [NUM_INPUTS-1:0]       in_eop;
    logic [NUM_INPUTS-1:0]       in_ready;

    logic                        out_valid;
    logic [DATAW-1:0]            out_data;
    logic                        out_sop;
    logic                        out_eop;
    logic [SEL_W-1:0]            out_sel;
    logic                        out_ready;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop,
        output in_ready,
        output out_valid, out_data, out_sop, out_eop, out_sel,
        input  out_ready
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop,
        input  in_ready,
        input  out_valid, out_data, out_sop, out_eop, out_sel,
        output out_ready
    );
endinterface

// File: rtl/vx_execute_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vx_execute_arbiter
//   Shares one functional-unit execute port between NUM_INPUTS issue slices.
//   Round-robin arbitration with packet locking: once a multi-beat packet
//   (sop without eop) is accepted from a slice, only that slice is granted
//   until its eop beat is accepted, so packets are never interleaved.
//   A single registered output stage gives 1-cycle latency at 1 beat/cycle.
//
//   Ports:
//     clk    - clock
//     reset  - asynchronous active-high reset
//     bus    - vx_execute_arbiter_if.slave (in_* request side, out_* FU side)
//   Optional (macro EXEC_ARB_PERF_EN):
//     perf_stalls     - cycles with any in_valid but nothing accepted
//     perf_lock_block - cycles where a non-owner is valid while locked
//   Both counters wrap modulo 2^32.
//
//   NUM_INPUTS == 1 degenerates to a pass-through register (out_sel = 0,
//   the lock never engages).
// -----------------------------------------------------------------------------
module vx_execute_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    vx_execute_arbiter_if.slave      bus
`ifdef EXEC_ARB_PERF_EN
    ,
    output logic [31:0]              perf_stalls,
    output logic [31:0]              perf_lock_block
`endif
);
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_INPUTS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam bit LOCK_EN = (NUM_INPUTS > 1);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  owner_q;
    logic [SEL_W-1:0]  rr_ptr_q;

    logic              out_valid_q;
    logic [DATAW-1:0]  out_data_q;
    logic              out_sop_q;
    logic              out_eop_q;
    logic [SEL_W-1:0]  out_sel_q;

    logic              stage_en;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_sel;
    logic [DATAW-1:0]  grant_data;
    logic              grant_sop;
    logic              grant_eop;
    logic              accept;
    logic [NUM_INPUTS-1:0] in_ready_c;

    // The output register can take a new beat when empty or draining now.
    assign stage_en = !out_valid_q || bus.out_ready;

    // -------------------------------------------------------------------------
    // Grant selection.
    // Unlocked: first valid slice at or after rr_ptr, wrapping. Implemented as
    // "lowest valid index >= rr_ptr, else lowest valid index overall".
    // Locked: the owner only, and only when it is presenting a beat.
    // -------------------------------------------------------------------------
    always_comb begin : arbitrate
        logic             hi_vld;
        logic [SEL_W-1:0] hi_sel;
        logic             lo_vld;
        logic [SEL_W-1:0] lo_sel;
        logic             owner_vld;
        // NOTE: every variable written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        hi_vld    = 1'b0;
        hi_sel    = '0;
        lo_vld    = 1'b0;
        lo_sel    = '0;
        owner_vld = 1'b0;
        grant_vld = 1'b0;
        grant_sel = '0;

        // Descending scan: the last hit written is the lowest index.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                lo_vld = 1'b1;
                lo_sel = SEL_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_sel = SEL_W'(i);
                end
            end
            if (SEL_W'(i) == owner_q) begin
                owner_vld = bus.in_valid[i];
            end
        end

        if (state_q == ST_LOCKED) begin
            grant_vld = owner_vld;
            grant_sel = owner_q;
        end else if (hi_vld) begin
            grant_vld = 1'b1;
            grant_sel = hi_sel;
        end else begin
            grant_vld = lo_vld;
            grant_sel = lo_sel;
        end
    end

    // Payload mux for the granted slice.
    always_comb begin : payload_mux
        grant_data = '0;
        grant_sop  = 1'b0;
        grant_eop  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SEL_W'(i) == grant_sel) begin
                grant_data = bus.in_data[i*DATAW +: DATAW];
                grant_sop  = bus.in_sop[i];
                grant_eop  = bus.in_eop[i];
            end
        end
    end

    // No beat is taken while reset is high; in-flight packets are dropped.
    assign accept = !reset && stage_en && grant_vld;

    always_comb begin : ready_decode
        in_ready_c = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready_c[i] = accept && (grant_sel == SEL_W'(i));
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_sel   = out_sel_q;

    // -------------------------------------------------------------------------
    // Lock FSM, round-robin pointer and output register in one process.
    // A lock release and the following grant are one cycle apart: the state
    // and pointer written here are only seen by arbitration next cycle.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and process ordering cannot matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the payload register is reset as well, because the FU
            // port must show all-zero data after reset, not just valid=0.
            state_q     <= ST_UNLOCKED;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_sop_q   <= grant_sop;
                out_eop_q   <= grant_eop;
                out_sel_q   <= grant_sel;

                if (grant_eop) begin
                    // End of packet (including single-beat sop&&eop):
                    // release and move the pointer past the sender.
                    state_q  <= ST_UNLOCKED;
                    rr_ptr_q <= (grant_sel == LAST_SEL) ? '0 : grant_sel + SEL_ONE;
                end else if (LOCK_EN && grant_sop && state_q == ST_UNLOCKED) begin
                    state_q <= ST_LOCKED;
                    owner_q <= grant_sel;
                end
                // Non-sop beats while unlocked, or a repeated sop from the
                // owner, pass through without touching the lock.
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef EXEC_ARB_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters.
    // -------------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] owner_oh;

    always_comb begin : owner_decode
        owner_oh = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            owner_oh[i] = (SEL_W'(i) == owner_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls     <= '0;
            perf_lock_block <= '0;
        end else begin
            if ((|bus.in_valid) && !accept) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            if (state_q == ST_LOCKED && (|(bus.in_valid & ~owner_oh))) begin
                perf_lock_block <= perf_lock_block + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // -------------------------------------------------------------------------
    // Simulation-only protocol and integrity checks.
    // -------------------------------------------------------------------------
    // A beat accepted while unlocked must open a packet.
    a_sop_when_unlocked: assert property (
        @(posedge clk) disable iff (reset)
        (accept && state_q == ST_UNLOCKED) |-> grant_sop
    ) else $error("vx_execute_arbiter: non-sop beat from slice %0d while unlocked", grant_sel);

    // The owner must not start a new packet before finishing its current one.
    a_no_sop_while_locked: assert property (
        @(posedge clk) disable iff (reset)
        (accept && state_q == ST_LOCKED) |-> !grant_sop
    ) else $error("vx_execute_arbiter: sop beat from owner %0d while locked", owner_q);

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (reset)
        $onehot0(bus.in_ready)
    ) else $error("vx_execute_arbiter: more than one in_ready asserted");

    a_out_stable: assert property (
        @(posedge clk) disable iff (reset)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_sel_q) &&
             $stable(out_sop_q) && $stable(out_eop_q))
    ) else $error("vx_execute_arbiter: output changed while stalled");
`endif

endmodule

// File: tb/tb_vx_execute_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vx_execute_arbiter
//   Directed bench for vx_execute_arbiter (NUM_INPUTS=4, DATAW=32).
//   Per-slice source queues feed the request side and honour the handshake;
//   a gap entry (valid=0) idles a slice for one cycle. Expected FU beats are
//   pushed into a scoreboard by hand, and a monitor pops and compares each
//   beat that transfers on the FU side.
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_vx_execute_arbiter;
    localparam int NI = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vx_execute_arbiter_if #(.NUM_INPUTS(NI), .DATAW(DW)) bus ();

`ifdef EXEC_ARB_PERF_EN
    logic [31:0] perf_stalls;
    logic [31:0] perf_lock_block;
`endif

    vx_execute_arbiter #(.NUM_INPUTS(NI), .DATAW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus)
`ifdef EXEC_ARB_PERF_EN
        ,
        .perf_stalls     (perf_stalls),
        .perf_lock_block (perf_lock_block)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } exp_t;

    beat_t src_q [NI][$];
    exp_t  sb [$];

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;

    logic [NI-1:0] s_ready;
    logic          s_out_valid;
    logic [SW-1:0] s_out_sel;
    logic [DW-1:0] s_out_data;
    logic [NI-1:0] fire;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pay(input int s, input int p, input int b);
        return {8'(s), 8'(p), 8'(b), 8'hA5};
    endfunction

    function automatic beat_t bt(input int s, input int p, input int b, input bit sop, input bit eop);
        return {1'b1, sop, eop, pay(s, p, b)};
    endfunction

    function automatic beat_t gap();
        return '0;
    endfunction

    task automatic expect_beat(input int s, input int p, input int b, input bit sop, input bit eop);
        sb.push_back({SW'(s), sop, eop, pay(s, p, b)});
    endtask

    function automatic bit all_empty();
        bit e;
        e = (sb.size() == 0);
        for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Drive each slice with the head of its queue.
    task automatic present();
        for (int i = 0; i < NI; i++) begin
            beat_t b;
            if (src_q[i].size() > 0) b = src_q[i][0];
            else b = '0;
            bus.in_valid[i]          = b.valid;
            bus.in_sop[i]            = b.sop;
            bus.in_eop[i]            = b.eop;
            bus.in_data[i*DW +: DW]  = b.data;
        end
    endtask

    // One clock: sample at the falling edge, then after the rising edge
    // retire accepted beats and one-cycle gaps and present the next heads.
    task automatic step();
        @(negedge clk);
        fire        = bus.in_valid & bus.in_ready;
        s_ready     = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_out_sel   = bus.out_sel;
        s_out_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) xfer_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (src_q[i].size() > 0 && (!src_q[i][0].valid || fire[i])) void'(src_q[i].pop_front());
        end
        present();
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (!all_empty() && c < 60) begin
            step();
            c++;
        end
        check({name, "_drained"}, 64'(all_empty()), 64'd1);
    endtask

    // Scoreboard monitor: every beat that transfers on the FU side.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            got = {bus.out_sel, bus.out_sop, bus.out_eop, bus.out_data};
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got beat 0x%0h, expected no beat", got);
            end else begin
                e = sb.pop_front();
                check("out_beat", 64'(got), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset state (inputs busy during reset) -------------
        bus.out_ready = 1'b1;
        bus.in_valid  = '1;
        bus.in_sop    = '1;
        bus.in_eop    = '1;
        bus.in_data   = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_sel",   64'(bus.out_sel),   64'd0);
        check("rst_out_sopeop", 64'({bus.out_sop, bus.out_eop}), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        present();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- T1: single-beat round robin at full rate ----------
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NI; s++) begin
                src_q[s].push_back(bt(s, p, 0, 1, 1));
                expect_beat(s, p, 0, 1, 1);
            end
        xfer_cnt = 0;
        present();
        repeat (9) step();
        check("t1_throughput", 64'(xfer_cnt), 64'd8);
        drain("t1");

        // ---------------- T2: 3-beat packet blocks slice 2 -------------------
        src_q[1].push_back(bt(1, 0, 0, 1, 0));
        src_q[1].push_back(bt(1, 0, 1, 0, 0));
        src_q[1].push_back(bt(1, 0, 2, 0, 1));
        src_q[2].push_back(bt(2, 0, 0, 1, 1));
        src_q[2].push_back(bt(2, 1, 0, 1, 1));
        expect_beat(1, 0, 0, 1, 0);
        expect_beat(1, 0, 1, 0, 0);
        expect_beat(1, 0, 2, 0, 1);
        expect_beat(2, 0, 0, 1, 1);
        expect_beat(2, 1, 0, 1, 1);
        present();
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_ready2_blocked", 64'(s_ready[2]), 64'd0);
            check("t2_ready1_owner",   64'(s_ready[1]), 64'd1);
        end
        step();
        check("t2_ready2_after_eop", 64'(s_ready[2]), 64'd1);
        drain("t2");

        // ---------------- T3: owner idles mid-packet ------------------------
        src_q[1].push_back(bt(1, 0, 0, 1, 0));
        src_q[1].push_back(gap());
        src_q[1].push_back(gap());
        src_q[1].push_back(bt(1, 0, 1, 0, 0));
        src_q[1].push_back(bt(1, 0, 2, 0, 1));
        src_q[3].push_back(gap());
        src_q[3].push_back(bt(3, 0, 0, 1, 1));
        expect_beat(1, 0, 0, 1, 0);
        expect_beat(1, 0, 1, 0, 0);
        expect_beat(1, 0, 2, 0, 1);
        expect_beat(3, 0, 0, 1, 1);
        present();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3 || k == 4) check("t3_no_out_valid", 64'(s_out_valid), 64'd0);
            if (k >= 2 && k <= 5) check("t3_ready3_blocked", 64'(s_ready[3]), 64'd0);
            if (k == 6) check("t3_ready3_after_eop", 64'(s_ready[3]), 64'd1);
        end
        drain("t3");

        // ---------------- T4: FU back-pressure for 5 cycles -----------------
        bus.out_ready = 1'b0;
        for (int s = 0; s < NI; s++) begin
            src_q[s].push_back(bt(s, 0, 0, 1, 1));
            expect_beat(s, 0, 0, 1, 1);
        end
        present();
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_hold_valid", 64'(s_out_valid), 64'd1);
            check("t4_hold_sel",   64'(s_out_sel),   64'd0);
            check("t4_hold_data",  64'(s_out_data),  64'(pay(0, 0, 0)));
            check("t4_ready_none", 64'(s_ready),     64'd0);
        end
        bus.out_ready = 1'b1;
        drain("t4");

        // ---------------- T5: reset in the middle of a locked packet --------
        src_q[1].push_back(bt(1, 0, 0, 1, 1));
        src_q[2].push_back(gap());
        src_q[2].push_back(bt(2, 0, 0, 1, 0));
        src_q[2].push_back(bt(2, 0, 1, 0, 0));
        src_q[2].push_back(bt(2, 0, 2, 0, 0));
        src_q[2].push_back(bt(2, 0, 3, 0, 1));
        expect_beat(1, 0, 0, 1, 1);
        expect_beat(2, 0, 0, 1, 0);
        present();
        repeat (3) step();
        check("t5_beat2_held", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, pay(2, 0, 1)}));
        reset = 1'b1;
        #1;
        check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_out_data",  64'(bus.out_data),  64'd0);
        check("t5_rst_out_sel",   64'(bus.out_sel),   64'd0);
        check("t5_rst_in_ready",  64'(bus.in_ready),  64'd0);
        for (int i = 0; i < NI; i++) src_q[i].delete();
        present();
        @(posedge clk);
        #1;
        reset = 1'b0;
        src_q[1].push_back(bt(1, 1, 0, 1, 1));
        src_q[3].push_back(bt(3, 1, 0, 1, 1));
        expect_beat(1, 1, 0, 1, 1);
        expect_beat(3, 1, 0, 1, 1);
        present();
        drain("t5");

`ifdef EXEC_ARB_PERF_EN
        // ---------------- T6: stall counter --------------------------------
        begin
            logic [31:0] snap;
            bus.out_ready = 1'b0;
            src_q[0].push_back(bt(0, 0, 0, 1, 1));
            src_q[0].push_back(bt(0, 1, 0, 1, 1));
            expect_beat(0, 0, 0, 1, 1);
            expect_beat(0, 1, 0, 1, 1);
            present();
            step();
            snap = perf_stalls;
            repeat (10) step();
            check("t6_perf_stalls_delta", 64'(perf_stalls - snap), 64'd10);
            bus.out_ready = 1'b1;
            drain("t6");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
